calab3_demux4: RTL and testbench
================================

# calab3_demux4

Registered 1-to-4 demultiplexer with per-lane buffering, the receive-side counterpart of the lab's 4-to-1 word multiplexer. An 8-bit word arriving on a single valid/ready input stream with a 2-bit lane select is steered into one of four output lanes. Each lane has its own small FIFO and its own valid/ready handshake, so a stalled lane blocks only words addressed to it. The block sits between a shared producer bus and four independent consumers.

## Interface
- N, 8: data word width in bits.
- DEPTH, 2: entries per lane FIFO; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_data  in  N  input word.
- in_sel  in  2  destination lane index, 0–3.
- in_valid  in  1  input word is present.
- in_ready  out  1  block accepts the word this cycle.
- out_data  out  4*N  lane k head word at bits [k*N +: N].
- out_valid  out  4  bit k: lane k holds a word.
- out_ready  in  4  bit k: consumer k takes the head word.
- lane_count  out  4*8  compiled in only with CALAB3_DEMUX_STATS_EN; lane k count at bits [k*8 +: 8].

## Operation
- Push: on a clk edge with in_valid && in_ready, in_data is written to the FIFO of lane in_sel.
- in_ready = !full[in_sel]. It depends only on the selected lane's state before the edge, never on same-cycle out_ready. There is no pass-through into a full lane.
- Pop: on a clk edge with out_valid[k] && out_ready[k], lane k advances its head.
- out_valid[k] = !empty[k].
- out_data lane k = head entry when non-empty, and 0 when empty.
- Per-lane order is strict FIFO. There is no ordering relation between lanes.
- Push and pop on the same lane in the same cycle, when the lane is neither empty nor full: both happen and occupancy is unchanged.
- Pop on a full lane in the same cycle as an attempted push to it: the pop happens and the push is refused (in_ready was 0).
- Pops on all four lanes and one push may occur in the same cycle.
- Each lane has read/write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- out_ready with out_valid low is ignored. in_sel is ignored when in_valid is low.

## Timing
- Push-to-output latency: 1 cycle. A word pushed at edge t shows out_valid high after edge t, on an empty lane.
- Throughput: 1 word/cycle on input; 1 word/cycle per lane on output.
- Reset values:
  - out_valid = 4'b0000, out_data = 0, lane_count = 0.
  - All pointers = 0.
  - in_ready = 0 while rst_n is low, and 1 on the first cycle after release.
- Reset mid-operation: all buffered words are discarded at that edge, and any push or pop in that cycle is ignored.

## Configuration
- CALAB3_DEMUX_STATS_EN defined:
  - lane_count port exists.
  - Each lane has an 8-bit counter that increments on every accepted push to that lane.
  - The counter saturates at 255 and clears only on reset.
- CALAB3_DEMUX_STATS_EN undefined: no counters and no lane_count port. Data-path behaviour is identical.

## Structure
- Package calab3_demux_pkg holds:
  - LANES = 4, SEL_W = 2, CNT_W = 8.
  - Typedef sel_t (logic [SEL_W-1:0]).
- Sub-module calab3_demux_lane_fifo (N, DEPTH): one lane's FIFO, with push, pop, full, empty and head outputs. The top instantiates it four times in a generate loop and holds the select decode, the in_ready mux and the optional counters.

## Test plan
- Reset, then push 8'h00/8'h01/8'h02/8'h03 with in_sel 0/1/2/3 and all out_ready = 1 → each lane outputs its word one cycle after its push, matching sel→lane.
- Hold out_ready[2] = 0 and push 8'hA0, A1, A2 to lane 2 → first two accepted, third sees in_ready = 0. Raise out_ready[2] → A0 then A1 in order, after which A2 is accepted.
- Lane 1 full, then push to lane 3 → accepted with no stall, showing lanes are independent.
- Lane 0 holding one word, simultaneous push of 8'h55 and pop → occupancy stays 1, and the head becomes 8'h55 next cycle.
- Two lanes loaded, then drive rst_n low for one cycle mid-stream → out_valid = 0, out_data = 0, and buffered words are never emitted.
- With CALAB3_DEMUX_STATS_EN: 300 pushes to lane 1 → lane_count[15:8] = 255, and other lanes read 0.

Source files
------------

// File: rtl/calab3_demux_pkg.sv
// Shared constants, lane-select type and counter helper for the calab3 1-to-4 demultiplexer.
package calab3_demux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;

  // Saturating increment: a counter stuck at all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/calab3_demux_lane_fifo.sv
// One output lane: a DEPTH-entry FIFO with wrap-bit pointers, zero head word when empty.
module calab3_demux_lane_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [N-1:0] head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][N-1:0] mem_q, mem_d;
  logic                    do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
  assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/calab3_demux4.sv
// Registered 1-to-4 demultiplexer with a FIFO per output lane.
// Define CALAB3_DEMUX_STATS_EN to add saturating per-lane push counters on lane_count.
module calab3_demux4
  import calab3_demux_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_data,
  input  sel_t               in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [LANES*N-1:0] out_data,
  output logic [LANES-1:0]   out_valid,
  input  logic [LANES-1:0]   out_ready
`ifdef CALAB3_DEMUX_STATS_EN
  ,
  output logic [LANES*CNT_W-1:0] lane_count
`endif
);

  // Handshake: a word moves on an edge where valid && ready are both high;
  // ready never depends on valid, and in_ready never looks at out_ready.
  logic [LANES-1:0]        full, empty, push, pop;
  logic [LANES-1:0][N-1:0] head;

  assign in_ready = rst_n && !full[in_sel];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign push[k] = in_valid && in_ready && (in_sel == sel_t'(k));
    assign pop[k]  = !empty[k] && out_ready[k];

    calab3_demux_lane_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[k]),
      .push_data (in_data),
      .pop       (pop[k]),
      .full      (full[k]),
      .empty     (empty[k]),
      .head      (head[k])
    );

    assign out_data[k*N +: N] = head[k];
    assign out_valid[k]       = !empty[k];
  end

`ifdef CALAB3_DEMUX_STATS_EN
  logic [LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < LANES; k++) begin
      if (push[k]) cnt_d[k] = sat_inc(cnt_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign lane_count = cnt_q;
`endif

endmodule

// File: tb/tb_calab3_demux4.sv
// Bench for calab3_demux4: directed vector table, random traffic against a queue model,
// and (with CALAB3_DEMUX_STATS_EN) counter saturation.
module tb_calab3_demux4;

  localparam int N     = 8;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [4*N-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
`ifdef CALAB3_DEMUX_STATS_EN
  logic [31:0]   lane_count;
`endif

  calab3_demux4 #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CALAB3_DEMUX_STATS_EN
    ,
    .lane_count(lane_count)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q [4][$];
  int         cnt_m [4];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return rst_n && (exp_q[in_sel].size() < DEPTH);
  endfunction

  task automatic check_model();
    logic [3:0]  ov;
    logic [31:0] od;
    ov = '0;
    od = '0;
    for (int k = 0; k < 4; k++) begin
      if (exp_q[k].size() > 0) begin
        ov[k]         = 1'b1;
        od[k*8 +: 8]  = exp_q[k][0];
      end
    end
    chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
    chk("out_valid", {28'b0, out_valid}, {28'b0, ov});
    chk("out_data", out_data, od);
`ifdef CALAB3_DEMUX_STATS_EN
    chk("lane_count", lane_count, {cnt_m[3][7:0], cnt_m[2][7:0], cnt_m[1][7:0], cnt_m[0][7:0]});
`endif
  endtask

  // Apply this cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] rdy);
    rst_n     = r;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
    #2;
  endtask

  // Update the model with what the coming edge must do, then cross it.
  task automatic advance();
    logic acc;
    acc = in_valid && model_ready();
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[k].delete();
        cnt_m[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (exp_q[k].size() > 0 && out_ready[k]) void'(exp_q[k].pop_front());
      if (acc) begin
        exp_q[in_sel].push_back(in_data);
        if (cnt_m[in_sel] < 255) cnt_m[in_sel]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       r;
    logic       v;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       exp_ir;
    logic [3:0] exp_ov;
    logic [7:0] exp_d0;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mkv(input logic r, input logic v, input logic [1:0] s,
                               input logic [7:0] d, input logic [3:0] rdy,
                               input logic ir, input logic [3:0] ov, input logic [7:0] d0);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d; t.rdy = rdy;
    t.exp_ir = ir; t.exp_ov = ov; t.exp_d0 = d0;
    return t;
  endfunction

  initial begin
    // sel -> lane, one word each, consumers always ready
    tbl[0]  = mkv(1, 1, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h00);
    tbl[1]  = mkv(1, 1, 1, 8'h01, 4'hF, 1, 4'b0001, 8'h00);
    tbl[2]  = mkv(1, 1, 2, 8'h02, 4'hF, 1, 4'b0010, 8'h00);
    tbl[3]  = mkv(1, 1, 3, 8'h03, 4'hF, 1, 4'b0100, 8'h00);
    tbl[4]  = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b1000, 8'h00);
    tbl[5]  = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h00);
    // lane 2 stalled: third word refused until the lane drains
    tbl[6]  = mkv(1, 1, 2, 8'hA0, 4'hB, 1, 4'b0000, 8'h00);
    tbl[7]  = mkv(1, 1, 2, 8'hA1, 4'hB, 1, 4'b0100, 8'h00);
    tbl[8]  = mkv(1, 1, 2, 8'hA2, 4'hB, 0, 4'b0100, 8'h00);
    tbl[9]  = mkv(1, 1, 2, 8'hA2, 4'hF, 0, 4'b0100, 8'h00);
    tbl[10] = mkv(1, 1, 2, 8'hA2, 4'hF, 1, 4'b0100, 8'h00);
    tbl[11] = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b0100, 8'h00);
    tbl[12] = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h00);
    // lane 1 full does not block lane 3
    tbl[13] = mkv(1, 1, 1, 8'hB0, 4'h0, 1, 4'b0000, 8'h00);
    tbl[14] = mkv(1, 1, 1, 8'hB1, 4'h0, 1, 4'b0010, 8'h00);
    tbl[15] = mkv(1, 1, 1, 8'hB2, 4'h0, 0, 4'b0010, 8'h00);
    tbl[16] = mkv(1, 1, 3, 8'hC0, 4'h0, 1, 4'b0010, 8'h00);
    tbl[17] = mkv(1, 0, 0, 8'h00, 4'h0, 1, 4'b1010, 8'h00);
    tbl[18] = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b1010, 8'h00);
    tbl[19] = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b0010, 8'h00);
    tbl[20] = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h00);
    // simultaneous push and pop on a one-deep lane 0
    tbl[21] = mkv(1, 1, 0, 8'h11, 4'h0, 1, 4'b0000, 8'h00);
    tbl[22] = mkv(1, 1, 0, 8'h55, 4'h1, 1, 4'b0001, 8'h11);
    tbl[23] = mkv(1, 0, 0, 8'h00, 4'h0, 1, 4'b0001, 8'h55);
    tbl[24] = mkv(1, 0, 0, 8'h00, 4'h1, 1, 4'b0001, 8'h55);
    tbl[25] = mkv(1, 0, 0, 8'h00, 4'h0, 1, 4'b0000, 8'h00);
    // reset mid-stream discards buffered words and ignores that cycle's push/pop
    tbl[26] = mkv(1, 1, 0, 8'hD0, 4'h0, 1, 4'b0000, 8'h00);
    tbl[27] = mkv(1, 1, 3, 8'hD3, 4'h0, 1, 4'b0001, 8'hD0);
    tbl[28] = mkv(0, 1, 1, 8'hD1, 4'hF, 0, 4'b1001, 8'hD0);
    tbl[29] = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h00);
    tbl[30] = mkv(1, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h00);
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    @(posedge clk);
    #1;

    // second reset cycle: state is now defined
    drive(0, 1, 2, 8'h77, 4'hF);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h0);
    chk("reset_out_valid", {28'b0, out_valid}, 32'h0);
    chk("reset_out_data", out_data, 32'h0);
`ifdef CALAB3_DEMUX_STATS_EN
    chk("reset_lane_count", lane_count, 32'h0);
`endif
    check_model();
    advance();

    for (int i = 0; i < 31; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].rdy);
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].exp_ir});
      chk($sformatf("vec%0d_out_valid", i), {28'b0, out_valid}, {28'b0, tbl[i].exp_ov});
      chk($sformatf("vec%0d_lane0_data", i), {24'b0, out_data[7:0]}, {24'b0, tbl[i].exp_d0});
      check_model();
      advance();
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            4'($urandom_range(0, 15)));
      check_model();
      advance();
    end

`ifdef CALAB3_DEMUX_STATS_EN
    drive(0, 0, 0, 8'h00, 4'hF);
    check_model();
    advance();
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 1, 8'($urandom_range(0, 255)), 4'hF);
      check_model();
      advance();
    end
    drive(1, 0, 0, 8'h00, 4'hF);
    chk("lane_count_saturated", lane_count, 32'h0000_FF00);
    check_model();
    advance();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
